// File: rtl/case_pkg.sv
// Shared definitions for the ASCII case-conversion stream blocks (tolower/toupper).
package case_pkg;

    localparam logic [7:0] ASCII_UC_LO    = 8'h41;
    localparam logic [7:0] ASCII_UC_HI    = 8'h5A;
    localparam logic [7:0] ASCII_LC_LO    = 8'h61;
    localparam logic [7:0] ASCII_LC_HI    = 8'h7A;
    localparam int         ASCII_CASE_BIT = 5;
    localparam logic [7:0] ASCII_NUL      = 8'h00;

    // Per-string framing state: IDLE until the first non-NUL byte of a string.
    typedef enum logic {
        IDLE   = 1'b0,
        IN_STR = 1'b1
    } str_state_t;

    // One FIFO entry: terminator flag plus the (possibly converted) byte.
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } byte_entry_t;

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UC_LO) && (b <= ASCII_UC_HI);
    endfunction

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= ASCII_LC_LO) && (b <= ASCII_LC_HI);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO of 9-bit entries (last flag + byte) with occupancy count.
module byte_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [8:0]    wdata,
    input  logic          pop,
    output logic [8:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);

    logic [DEPTH-1:0][8:0] mem;
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic                  push_eff;
    logic                  pop_eff;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push_eff = push && !full;
    assign pop_eff  = pop && !empty;

    // Head is forced to zero when empty so the idle output reads as all-zero.
    assign rdata = empty ? 9'h000 : mem[rptr];

    // Occupancy for the next cycle; lets the owner register its ready flag.
    always_comb begin
        count_next = count;
        case ({push_eff, pop_eff})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_eff) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop_eff) begin
                rptr <= rptr + AW'(1);
            end
            count <= count_next;
        end
    end

endmodule

// File: rtl/tolower_stream.sv
// Streaming ASCII uppercase-to-lowercase converter with per-string statistics.
module tolower_stream
    import case_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             str_done,
    output logic [CNT_W-1:0] str_len,
    output logic [CNT_W-1:0] str_conv_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    logic          accept;
    logic          conv;
    logic          is_nul;
    byte_entry_t   wentry;
    byte_entry_t   rentry;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] fifo_count_next;
    logic          pop;

    str_state_t        state_q;
    str_state_t        state_d;
    logic              complete;
    logic [CNT_W-1:0]  run_len;
    logic [CNT_W-1:0]  run_conv;

    assign accept = in_valid && in_ready;
    assign is_nul = (in_data == ASCII_NUL);
    assign conv   = !bypass && is_upper(in_data);
    assign pop    = out_valid && out_ready;

    // Build the entry to push: set the case bit on convertible bytes, flag NUL.
    always_comb begin
        wentry                      = '0;
        wentry.data                 = in_data;
        wentry.data[ASCII_CASE_BIT] = in_data[ASCII_CASE_BIT] | conv;
        wentry.last                 = is_nul;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (accept),
        .wdata      (wentry),
        .pop        (pop),
        .rdata      (rentry),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (fifo_count_next)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = rentry.data;
    assign out_last  = rentry.last;

    // Registered ready from next occupancy only: no path from out_ready to in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
        end else begin
            in_ready <= (fifo_count_next < CW'(FIFO_DEPTH));
        end
    end

    // Framing state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and completion strobe; a NUL in either state ends a string.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        if (accept) begin
            if (is_nul) begin
                state_d  = IDLE;
                complete = 1'b1;
            end else begin
                state_d  = IN_STR;
            end
        end
    end

    // Saturating running counters, snapshot into the held outputs on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len      <= '0;
            run_conv     <= '0;
            str_len      <= '0;
            str_conv_cnt <= '0;
            str_done     <= 1'b0;
        end else begin
            str_done <= complete;
            if (complete) begin
                str_len      <= run_len;
                str_conv_cnt <= run_conv;
                run_len      <= '0;
                run_conv     <= '0;
            end else if (accept) begin
                if (run_len != '1) begin
                    run_len <= run_len + CNT_W'(1);
                end
                if (conv && (run_conv != '1)) begin
                    run_conv <= run_conv + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tolower_stream.sv
// Scoreboard bench for tolower_stream: driver queues expectations, monitor checks output.
module tb_tolower_stream;

    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             bypass = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_last;
    logic             str_done;
    logic [CNT_W-1:0] str_len;
    logic [CNT_W-1:0] str_conv_cnt;

    int tests = 0;
    int fails = 0;

    logic [8:0]         byte_q[$];
    logic [2*CNT_W-1:0] str_q[$];

    tolower_stream #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .bypass       (bypass),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .str_done     (str_done),
        .str_len      (str_len),
        .str_conv_cnt (str_conv_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one byte until accepted; returns on the negedge after the accept edge.
    task automatic send(input logic [7:0] d, input logic b, input logic [7:0] e);
        byte_q.push_back({(d == 8'h00), e});
        in_valid = 1'b1;
        in_data  = d;
        bypass   = b;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    // Change out_ready just after a rising edge so it is stable at the monitor's sample.
    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 out_ready = v;
    endtask

    task automatic expect_str(input logic [CNT_W-1:0] len, input logic [CNT_W-1:0] cv);
        str_q.push_back({len, cv});
    endtask

    // Monitor: compare every popped byte and every completion against the queues.
    initial begin
        logic [8:0]         eb;
        logic [2*CNT_W-1:0] es;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (byte_q.size() == 0) begin
                        chk("unexpected_byte", {23'd0, out_last, out_data}, 32'h1ff);
                    end else begin
                        eb = byte_q.pop_front();
                        chk("out_byte", {23'd0, out_last, out_data}, {23'd0, eb});
                    end
                end
                if (str_done) begin
                    if (str_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        es = str_q.pop_front();
                        chk("str_len", {28'd0, str_len}, {28'd0, es[2*CNT_W-1:CNT_W]});
                        chk("str_conv", {28'd0, str_conv_cnt}, {28'd0, es[CNT_W-1:0]});
                    end
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_str_done", {31'd0, str_done}, 32'd0);
        chk("rst_str_len", {28'd0, str_len}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

        // "Hello\0"
        set_ready(1'b1);
        @(negedge clk);
        send(8'h48, 1'b0, 8'h68);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        send(8'h65, 1'b0, 8'h65);
        send(8'h6C, 1'b0, 8'h6C);
        send(8'h6C, 1'b0, 8'h6C);
        send(8'h6F, 1'b0, 8'h6F);
        expect_str(4'd5, 4'd1);
        send(8'h00, 1'b0, 8'h00);
        chk("done_pulse", {31'd0, str_done}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, str_done}, 32'd0);
        chk("len_held", {28'd0, str_len}, 32'd5);

        // Range boundaries
        send(8'h40, 1'b0, 8'h40);
        send(8'h41, 1'b0, 8'h61);
        send(8'h5A, 1'b0, 8'h7A);
        send(8'h5B, 1'b0, 8'h5B);
        send(8'h60, 1'b0, 8'h60);
        send(8'h61, 1'b0, 8'h61);
        send(8'h7A, 1'b0, 8'h7A);
        send(8'hC1, 1'b0, 8'hC1);
        send(8'hDA, 1'b0, 8'hDA);
        expect_str(4'd9, 4'd2);
        send(8'h00, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Backpressure: fill the FIFO, hold the third byte, then drain
        set_ready(1'b0);
        @(negedge clk);
        send(8'h41, 1'b0, 8'h61);
        send(8'h42, 1'b0, 8'h62);
        fork
            send(8'h43, 1'b0, 8'h63);
            begin
                for (int i = 0; i < 3; i++) begin
                    chk("full_not_ready", {31'd0, in_ready}, 32'd0);
                    @(negedge clk);
                end
                chk("full_valid", {31'd0, out_valid}, 32'd1);
                chk("full_head_stable", {24'd0, out_data}, 32'h61);
                set_ready(1'b1);
            end
        join
        expect_str(4'd3, 4'd3);
        send(8'h00, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Bypass per byte
        send(8'h41, 1'b1, 8'h41);
        send(8'h42, 1'b1, 8'h42);
        send(8'h43, 1'b0, 8'h63);
        expect_str(4'd3, 4'd1);
        send(8'h00, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Reset mid-string with bytes still buffered
        set_ready(1'b0);
        @(negedge clk);
        send(8'h41, 1'b0, 8'h61);
        send(8'h42, 1'b0, 8'h62);
        rst_n = 1'b0;
        byte_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out_data", {23'd0, out_last, out_data}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_str_len", {28'd0, str_len}, 32'd0);
        chk("mid_rst_str_conv", {28'd0, str_conv_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
        set_ready(1'b1);
        @(negedge clk);
        send(8'h78, 1'b0, 8'h78);
        expect_str(4'd1, 4'd0);
        send(8'h00, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        // Saturation: twenty 'A' then two NULs
        for (int i = 0; i < 20; i++) send(8'h41, 1'b0, 8'h61);
        expect_str(4'd15, 4'd15);
        send(8'h00, 1'b0, 8'h00);
        expect_str(4'd0, 4'd0);
        send(8'h00, 1'b0, 8'h00);
        chk("second_done", {31'd0, str_done}, 32'd1);

        // Drain and confirm nothing outstanding
        for (int i = 0; i < 50; i++) begin
            if (byte_q.size() == 0 && str_q.size() == 0) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("bytes_drained", byte_q.size(), 32'd0);
        chk("strs_drained", str_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
